// File: rtl/inter_read_xbar.sv
// Read crossbar connecting NUM_MASTERS read masters to NUM_SLAVES read slaves.
//
// Each master address is decoded against per-slave (mask, match) pairs, with the
// lowest-numbered matching slave taking the request. Each slave has a
// combinational round-robin arbiter. Accepted reads are tracked in fixed-latency
// pipelines so read data returns exactly RD_LATENCY cycles after the grant.
// Addresses that match no slave are granted at once and answered with err=1.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   master_data_req_i     - per-master read request
//   master_data_addr_i    - packed per-master read address
//   master_data_gnt_o     - per-master request accepted this cycle
//   master_data_rvalid_o  - per-master response valid
//   master_data_rdata_o   - packed per-master response data
//   master_data_err_o     - per-master decode error (qualified by rvalid)
//   slave_data_req_o      - per-slave request
//   slave_data_addr_o     - packed per-slave address (low S_ADDR_WIDTH bits)
//   slave_data_gnt_i      - per-slave accept
//   slave_data_rdata_i    - packed per-slave read data, valid RD_LATENCY after accept
module inter_read_xbar #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned M_ADDR_WIDTH = 11,
    parameter int unsigned S_ADDR_WIDTH = 10,
    parameter int unsigned NUM_MASTERS  = 2,
    parameter int unsigned NUM_SLAVES   = 2,
    parameter int unsigned RD_LATENCY   = 1,
    parameter logic [NUM_SLAVES*M_ADDR_WIDTH-1:0] M_ADDR_MATCH = 22'h200000,
    parameter logic [NUM_SLAVES*M_ADDR_WIDTH-1:0] M_ADDR_MASK  = 22'h200400
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            master_data_req_i,
    input  logic [NUM_MASTERS*M_ADDR_WIDTH-1:0] master_data_addr_i,
    output logic [NUM_MASTERS-1:0]            master_data_gnt_o,
    output logic [NUM_MASTERS-1:0]            master_data_rvalid_o,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] master_data_rdata_o,
    output logic [NUM_MASTERS-1:0]            master_data_err_o,
    output logic [NUM_SLAVES-1:0]             slave_data_req_o,
    output logic [NUM_SLAVES*S_ADDR_WIDTH-1:0] slave_data_addr_o,
    input  logic [NUM_SLAVES-1:0]             slave_data_gnt_i,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  slave_data_rdata_i
);

    localparam int NM    = int'(NUM_MASTERS);
    localparam int NS    = int'(NUM_SLAVES);
    localparam int LAT   = int'(RD_LATENCY);
    localparam int AW    = int'(M_ADDR_WIDTH);
    localparam int SW    = int'(S_ADDR_WIDTH);
    localparam int DW    = int'(DATA_WIDTH);
    localparam int IDX_W = (NM > 1) ? $clog2(NM) : 1;
    localparam int SEL_W = (NS > 1) ? $clog2(NS) : 1;

    logic [NM-1:0]    m_hit;
    logic [SEL_W-1:0] m_sel [NM];
    logic [NM-1:0]    m_err_req;

    logic [NS-1:0]    s_found;
    logic [NS-1:0]    s_acc;
    logic [IDX_W-1:0] s_win [NS];

    logic [IDX_W-1:0] ptr_q   [NS];
    logic [LAT-1:0]   s_vld_q [NS];
    logic [IDX_W-1:0] s_idx_q [NS][LAT];
    logic [LAT-1:0]   e_vld_q [NM];

    // Address decode; scanning downwards lets the lowest matching slave win.
    always_comb begin
        for (int m = 0; m < NM; m++) begin
            m_hit[m] = 1'b0;
            m_sel[m] = '0;
            for (int s = NS - 1; s >= 0; s--) begin
                if ((master_data_addr_i[m*AW +: AW] & M_ADDR_MASK[s*AW +: AW])
                        == M_ADDR_MATCH[s*AW +: AW]) begin
                    m_hit[m] = 1'b1;
                    m_sel[m] = SEL_W'(s);
                end
            end
            m_err_req[m] = master_data_req_i[m] & ~m_hit[m] & ~reset;
        end
    end

    // Round-robin search per slave starting at its priority pointer.
    always_comb begin
        int idx;
        idx = 0;
        for (int s = 0; s < NS; s++) begin
            s_found[s] = 1'b0;
            s_win[s]   = '0;
            for (int k = 0; k < NM; k++) begin
                idx = int'(ptr_q[s]) + k;
                if (idx >= NM) begin
                    idx = idx - NM;
                end
                if (!s_found[s] && master_data_req_i[idx] && m_hit[idx]
                        && (m_sel[idx] == SEL_W'(s))) begin
                    s_found[s] = 1'b1;
                    s_win[s]   = IDX_W'(idx);
                end
            end
        end
    end

    always_comb begin
        slave_data_addr_o = '0;
        for (int s = 0; s < NS; s++) begin
            slave_data_req_o[s] = s_found[s] & ~reset;
            s_acc[s]            = slave_data_req_o[s] & slave_data_gnt_i[s];
            if (slave_data_req_o[s]) begin
                slave_data_addr_o[s*SW +: SW] = master_data_addr_i[int'(s_win[s])*AW +: SW];
            end
        end
    end

    always_comb begin
        for (int m = 0; m < NM; m++) begin
            master_data_gnt_o[m] = m_err_req[m];
            for (int s = 0; s < NS; s++) begin
                if (s_acc[s] && (s_win[s] == IDX_W'(m))) begin
                    master_data_gnt_o[m] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NS; s++) begin
                ptr_q[s]   <= '0;
                s_vld_q[s] <= '0;
                for (int k = 0; k < LAT; k++) begin
                    s_idx_q[s][k] <= '0;
                end
            end
            for (int m = 0; m < NM; m++) begin
                e_vld_q[m] <= '0;
            end
        end else begin
            for (int s = 0; s < NS; s++) begin
                if (s_acc[s]) begin
                    ptr_q[s] <= (s_win[s] == IDX_W'(NM - 1)) ? '0 : s_win[s] + 1'b1;
                end
                for (int k = LAT - 1; k > 0; k--) begin
                    s_vld_q[s][k] <= s_vld_q[s][k-1];
                    s_idx_q[s][k] <= s_idx_q[s][k-1];
                end
                s_vld_q[s][0] <= s_acc[s];
                s_idx_q[s][0] <= s_win[s];
            end
            for (int m = 0; m < NM; m++) begin
                for (int k = LAT - 1; k > 0; k--) begin
                    e_vld_q[m][k] <= e_vld_q[m][k-1];
                end
                e_vld_q[m][0] <= m_err_req[m];
            end
        end
    end

    // Response routing; a master is granted at most once per cycle, so heads never collide.
    always_comb begin
        master_data_rdata_o = '0;
        for (int m = 0; m < NM; m++) begin
            master_data_rvalid_o[m] = e_vld_q[m][LAT-1];
            master_data_err_o[m]    = e_vld_q[m][LAT-1];
        end
        for (int s = 0; s < NS; s++) begin
            if (s_vld_q[s][LAT-1]) begin
                master_data_rvalid_o[s_idx_q[s][LAT-1]] = 1'b1;
                master_data_rdata_o[int'(s_idx_q[s][LAT-1])*DW +: DW] =
                    slave_data_rdata_i[s*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_inter_read_xbar.sv
// Bench for inter_read_xbar. Instance A: 2 masters, 2 slaves, latency 2, with an
// unmapped hole at 0x200-0x3FF (directed scenarios, then random). Instance B:
// 3 masters, 4 slaves, latency 3, overlapping slave windows and a hole at
// 0x600-0x7FF (random traffic with a mid-run reset).
module tb_inter_read_xbar;

    logic clk;
    logic rst_a, rst_b;
    int   cyc;
    int   n_chk, n_pass;

    logic [1:0]   a_req, a_gnt, a_rvalid, a_err, a_sreq, a_sgnt;
    logic [21:0]  a_addr;
    logic [63:0]  a_rdata, a_srdata;
    logic [19:0]  a_saddr;

    logic [2:0]   b_req, b_gnt, b_rvalid, b_err;
    logic [32:0]  b_addr;
    logic [95:0]  b_rdata;
    logic [3:0]   b_sreq, b_sgnt;
    logic [39:0]  b_saddr;
    logic [127:0] b_srdata;

    inter_read_xbar #(
        .DATA_WIDTH(32), .M_ADDR_WIDTH(11), .S_ADDR_WIDTH(10),
        .NUM_MASTERS(2), .NUM_SLAVES(2), .RD_LATENCY(2),
        .M_ADDR_MATCH({11'h400, 11'h000}),
        .M_ADDR_MASK ({11'h400, 11'h600})
    ) u_a (
        .clk(clk), .reset(rst_a),
        .master_data_req_i(a_req), .master_data_addr_i(a_addr),
        .master_data_gnt_o(a_gnt), .master_data_rvalid_o(a_rvalid),
        .master_data_rdata_o(a_rdata), .master_data_err_o(a_err),
        .slave_data_req_o(a_sreq), .slave_data_addr_o(a_saddr),
        .slave_data_gnt_i(a_sgnt), .slave_data_rdata_i(a_srdata)
    );

    inter_read_xbar #(
        .DATA_WIDTH(32), .M_ADDR_WIDTH(11), .S_ADDR_WIDTH(10),
        .NUM_MASTERS(3), .NUM_SLAVES(4), .RD_LATENCY(3),
        .M_ADDR_MATCH({11'h400, 11'h400, 11'h200, 11'h000}),
        .M_ADDR_MASK ({11'h600, 11'h700, 11'h600, 11'h600})
    ) u_b (
        .clk(clk), .reset(rst_b),
        .master_data_req_i(b_req), .master_data_addr_i(b_addr),
        .master_data_gnt_o(b_gnt), .master_data_rvalid_o(b_rvalid),
        .master_data_rdata_o(b_rdata), .master_data_err_o(b_err),
        .slave_data_req_o(b_sreq), .slave_data_addr_o(b_saddr),
        .slave_data_gnt_i(b_sgnt), .slave_data_rdata_i(b_srdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- per-instance accessors ----------------
    function automatic int nm(input int i);  return (i == 0) ? 2 : 3; endfunction
    function automatic int ns(input int i);  return (i == 0) ? 2 : 4; endfunction
    function automatic int lat(input int i); return (i == 0) ? 2 : 3; endfunction

    function automatic logic get_rst(input int i); return (i == 0) ? rst_a : rst_b; endfunction
    function automatic logic get_req(input int i, input int m);
        return (i == 0) ? a_req[m] : b_req[m];
    endfunction
    function automatic logic [10:0] get_addr(input int i, input int m);
        return (i == 0) ? a_addr[m*11 +: 11] : b_addr[m*11 +: 11];
    endfunction
    function automatic logic get_gnt(input int i, input int m);
        return (i == 0) ? a_gnt[m] : b_gnt[m];
    endfunction
    function automatic logic get_rvalid(input int i, input int m);
        return (i == 0) ? a_rvalid[m] : b_rvalid[m];
    endfunction
    function automatic logic get_err(input int i, input int m);
        return (i == 0) ? a_err[m] : b_err[m];
    endfunction
    function automatic logic [31:0] get_rdata(input int i, input int m);
        return (i == 0) ? a_rdata[m*32 +: 32] : b_rdata[m*32 +: 32];
    endfunction
    function automatic logic get_sreq(input int i, input int s);
        return (i == 0) ? a_sreq[s] : b_sreq[s];
    endfunction
    function automatic logic get_sgnt(input int i, input int s);
        return (i == 0) ? a_sgnt[s] : b_sgnt[s];
    endfunction
    function automatic logic [9:0] get_saddr(input int i, input int s);
        return (i == 0) ? a_saddr[s*10 +: 10] : b_saddr[s*10 +: 10];
    endfunction

    // Address map as plain ranges; -1 means unmapped.
    function automatic int decode(input int i, input logic [10:0] a);
        if (i == 0) begin
            if (a < 11'h200) return 0;
            if (a < 11'h400) return -1;
            return 1;
        end
        if (a < 11'h200) return 0;
        if (a < 11'h400) return 1;
        if (a < 11'h500) return 2;
        if (a < 11'h600) return 3;
        return -1;
    endfunction

    // Content of every slave "memory": tagged with instance, slave and address.
    function automatic logic [31:0] mem(input int i, input int s, input logic [9:0] a);
        return {8'(i * 16 + s + 1), 6'd0, a, 8'hC3};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        int          due;
        bit          err;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q [6][$];
    int   next_pri [2][4];
    bit   gseen [2][3];
    bit   pend_v [2][4][8];
    logic [31:0] pend_d [2][4][8];

    task automatic model_step(input int i);
        bit [2:0]  pg;
        bit [3:0]  psr;
        logic [9:0] pa [4];
        exp_t e;
        int   w;
        pg  = '0;
        psr = '0;
        for (int s = 0; s < 4; s++) pa[s] = '0;
        if (get_rst(i)) begin
            for (int s = 0; s < 4; s++) next_pri[i][s] = 0;
            // Everything still in flight past this cycle is discarded.
            for (int m = 0; m < 3; m++) begin
                while (exp_q[i*3+m].size() > 0 &&
                       exp_q[i*3+m][exp_q[i*3+m].size()-1].due > cyc)
                    void'(exp_q[i*3+m].pop_back());
            end
        end else begin
            for (int m = 0; m < nm(i); m++) begin
                if (get_req(i, m) && decode(i, get_addr(i, m)) < 0) begin
                    pg[m] = 1'b1;
                    e.due = cyc + lat(i); e.err = 1'b1; e.data = '0;
                    exp_q[i*3+m].push_back(e);
                end
            end
            for (int s = 0; s < ns(i); s++) begin
                w = -1;
                for (int k = 0; k < nm(i) && w < 0; k++) begin
                    int c;
                    c = (next_pri[i][s] + k) % nm(i);
                    if (get_req(i, c) && decode(i, get_addr(i, c)) == s) w = c;
                end
                if (w >= 0) begin
                    psr[s] = 1'b1;
                    pa[s]  = get_addr(i, w) & 11'h3FF;
                    if (get_sgnt(i, s)) begin
                        pg[w] = 1'b1;
                        next_pri[i][s] = (w + 1) % nm(i);
                        e.due = cyc + lat(i); e.err = 1'b0; e.data = mem(i, s, pa[s]);
                        exp_q[i*3+w].push_back(e);
                    end
                end
            end
        end
        for (int m = 0; m < nm(i); m++) begin
            check($sformatf("gnt[%0d][%0d]", i, m), 32'(get_gnt(i, m)), 32'(pg[m]));
            gseen[i][m] = get_gnt(i, m);
        end
        for (int s = 0; s < ns(i); s++) begin
            check($sformatf("slave_req[%0d][%0d]", i, s), 32'(get_sreq(i, s)), 32'(psr[s]));
            if (psr[s]) check($sformatf("slave_addr[%0d][%0d]", i, s),
                              32'(get_saddr(i, s)), 32'(pa[s]));
            // Slave behaviour: remember what the DUT actually handed over.
            if (get_sreq(i, s) && get_sgnt(i, s)) begin
                pend_v[i][s][(cyc + lat(i)) % 8] = 1'b1;
                pend_d[i][s][(cyc + lat(i)) % 8] = mem(i, s, get_saddr(i, s));
            end
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // Response monitor.
    always begin
        exp_t e;
        @(negedge clk);
        if (cyc >= 1) begin
            for (int i = 0; i < 2; i++) begin
                for (int m = 0; m < nm(i); m++) begin
                    int q;
                    q = i * 3 + m;
                    if (get_rvalid(i, m)) begin
                        if (exp_q[q].size() == 0) begin
                            check($sformatf("unexpected_rvalid[%0d][%0d]", i, m), 32'd1, 32'd0);
                        end else begin
                            e = exp_q[q].pop_front();
                            check($sformatf("rsp_cycle[%0d][%0d]", i, m), 32'(cyc), 32'(e.due));
                            check($sformatf("rsp_err[%0d][%0d]", i, m),
                                  32'(get_err(i, m)), 32'(e.err));
                            check($sformatf("rsp_data[%0d][%0d]", i, m), get_rdata(i, m), e.data);
                        end
                    end else begin
                        check($sformatf("idle_rdata[%0d][%0d]", i, m), get_rdata(i, m), 32'd0);
                        check($sformatf("idle_err[%0d][%0d]", i, m), 32'(get_err(i, m)), 32'd0);
                        if (exp_q[q].size() > 0 && exp_q[q][0].due <= cyc) begin
                            check($sformatf("missing_rvalid[%0d][%0d]", i, m), 32'd0, 32'd1);
                            void'(exp_q[q].pop_front());
                        end
                    end
                end
            end
        end
    end

    // Slave read-data drivers: due data, otherwise junk.
    always begin
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            a_srdata[s*32 +: 32] = pend_v[0][s][cyc % 8] ? pend_d[0][s][cyc % 8] : $urandom;
            pend_v[0][s][cyc % 8] = 1'b0;
        end
        for (int s = 0; s < 4; s++) begin
            b_srdata[s*32 +: 32] = pend_v[1][s][cyc % 8] ? pend_d[1][s][cyc % 8] : $urandom;
            pend_v[1][s][cyc % 8] = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step_a(input bit r0, input logic [10:0] a0, input bit r1,
                          input logic [10:0] a1, input bit [1:0] g, input bit r);
        rst_a  = r;
        a_req  = {r1, r0};
        a_addr = {a1, a0};
        a_sgnt = g;
        @(posedge clk);
        #1;
    endtask

    task automatic run_a();
        step_a(0, 0, 0, 0, 2'b11, 1);
        step_a(0, 0, 0, 0, 2'b11, 1);
        // Both masters hammer slave 0: grants alternate from M0.
        repeat (8) step_a(1, 11'h010, 1, 11'h020, 2'b11, 0);
        repeat (3) step_a(0, 0, 0, 0, 2'b11, 0);
        // Different slaves in the same cycle.
        step_a(1, 11'h000, 1, 11'h400, 2'b11, 0);
        repeat (3) step_a(0, 0, 0, 0, 2'b11, 0);
        // Unmapped address.
        step_a(0, 0, 1, 11'h300, 2'b11, 0);
        repeat (3) step_a(0, 0, 0, 0, 2'b11, 0);
        // Slave 0 stalls under contention, then accepts.
        repeat (3) step_a(1, 11'h044, 1, 11'h088, 2'b10, 0);
        repeat (2) step_a(1, 11'h044, 1, 11'h088, 2'b11, 0);
        repeat (3) step_a(0, 0, 0, 0, 2'b11, 0);
        // Move the pointer to M1, then reset with a read in flight.
        step_a(1, 11'h0AA, 0, 0, 2'b11, 0);
        step_a(0, 0, 0, 0, 2'b11, 1);
        step_a(0, 0, 0, 0, 2'b11, 1);
        step_a(1, 11'h011, 1, 11'h022, 2'b11, 0);
        repeat (4) step_a(0, 0, 0, 0, 2'b11, 0);
        // Random traffic; masters hold req/addr until granted.
        for (int c = 0; c < 150; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!a_req[m] || gseen[0][m]) begin
                    a_req[m] = ($urandom_range(0, 99) < 60);
                    a_addr[m*11 +: 11] = 11'($urandom);
                end
            end
            for (int s = 0; s < 2; s++) a_sgnt[s] = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        a_req = '0;
        a_sgnt = '1;
    endtask

    task automatic run_b();
        rst_b = 1'b1; b_req = '0; b_addr = '0; b_sgnt = '1;
        repeat (3) begin @(posedge clk); #1; end
        rst_b = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rst_b = (c >= 300 && c < 302);
            for (int m = 0; m < 3; m++) begin
                if (!b_req[m] || gseen[1][m]) begin
                    b_req[m] = ($urandom_range(0, 99) < 70);
                    b_addr[m*11 +: 11] = 11'($urandom);
                end
            end
            for (int s = 0; s < 4; s++) b_sgnt[s] = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        rst_b = 1'b0;
        b_req = '0;
    endtask

    initial begin
        cyc = 0; n_chk = 0; n_pass = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        a_req = '0; a_addr = '0; a_sgnt = '1; a_srdata = '0;
        b_req = '0; b_addr = '0; b_sgnt = '1; b_srdata = '0;
        for (int i = 0; i < 2; i++)
            for (int s = 0; s < 4; s++) begin
                next_pri[i][s] = 0;
                for (int k = 0; k < 8; k++) begin
                    pend_v[i][s][k] = 1'b0;
                    pend_d[i][s][k] = '0;
                end
            end
        for (int i = 0; i < 2; i++)
            for (int m = 0; m < 3; m++) gseen[i][m] = 1'b0;
        fork
            run_a();
            run_b();
        join
        repeat (6) begin @(posedge clk); #1; end
        for (int q = 0; q < 6; q++)
            check($sformatf("drained[%0d]", q), 32'(exp_q[q].size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
